// File: rtl/pe_acc_ctrl.sv
// Sequencer for the 32-lane PE dot-product datapath: streams N chunks through the
// adder tree, accumulates the per-chunk sums and hands the total out on valid/ready.
module pe_acc_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] vec_num,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      tree_result,
  output logic [CNT_W-1:0] chunk_idx,
  output logic [31:0]      result,
  output logic             result_valid,
  input  logic             result_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic [31:0]      acc_r, acc_s;
  logic [31:0]      sum_s;
  logic [CNT_W-1:0] remaining_r, remaining_s;
  logic [CNT_W-1:0] chunk_idx_r, chunk_idx_s;
  logic [31:0]      result_r, result_s;
  logic             result_valid_r, result_valid_s;

  // Next-state and datapath update for the sequencer
  always_comb begin
    state_s        = state_r;
    acc_s          = acc_r;
    remaining_s    = remaining_r;
    chunk_idx_s    = chunk_idx_r;
    result_s       = result_r;
    result_valid_s = result_valid_r;
    sum_s          = acc_r + tree_result;
    case (state_r)
      IDLE: begin
        if (start) begin
          acc_s = 32'd0;
          if (vec_num != CNT_ZERO) begin
            remaining_s = vec_num;
            chunk_idx_s = CNT_ZERO;
            state_s     = ACC;
          end else begin
            // Empty vector: report a zero result without touching the datapath
            result_s       = 32'd0;
            result_valid_s = 1'b1;
            state_s        = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_s       = sum_s;
          chunk_idx_s = chunk_idx_r + CNT_ONE;
          remaining_s = remaining_r - CNT_ONE;
          if (remaining_r == CNT_ONE) begin
            // Capture the total on the last acceptance so result_valid rises with no gap
            result_s       = sum_s;
            result_valid_s = 1'b1;
            state_s        = DONE;
          end else begin
            state_s = ACC;
          end
        end else begin
          state_s = ACC;
        end
      end
      DONE: begin
        if (result_ready) begin
          result_valid_s = 1'b0;
          chunk_idx_s    = CNT_ZERO;
          state_s        = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s        = IDLE;
        result_valid_s = 1'b0;
        chunk_idx_s    = CNT_ZERO;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      acc_r          <= 32'd0;
      remaining_r    <= CNT_ZERO;
      chunk_idx_r    <= CNT_ZERO;
      result_r       <= 32'd0;
      result_valid_r <= 1'b0;
    end else begin
      state_r        <= state_s;
      acc_r          <= acc_s;
      remaining_r    <= remaining_s;
      chunk_idx_r    <= chunk_idx_s;
      result_r       <= result_s;
      result_valid_r <= result_valid_s;
    end
  end

  assign in_ready     = (state_r == ACC);
  assign busy         = (state_r != IDLE);
  assign chunk_idx    = chunk_idx_r;
  assign result       = result_r;
  assign result_valid = result_valid_r;

endmodule

// File: tb/tb_pe_acc_ctrl.sv
// Directed self-checking bench for pe_acc_ctrl; each task drives one scenario
// and compares outputs against hand-computed values.
module tb_pe_acc_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  vec_num;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] tree_result;
  logic [7:0]  chunk_idx;
  logic [31:0] result;
  logic        result_valid;
  logic        result_ready;

  int pass_cnt = 0;
  int total_cnt = 0;

  pe_acc_ctrl #(.CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .vec_num      (vec_num),
    .busy         (busy),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .tree_result  (tree_result),
    .chunk_idx    (chunk_idx),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; observations are taken 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [7:0] n);
    start   = 1'b1;
    vec_num = n;
    step();
    start   = 1'b0;
  endtask

  task automatic send(input logic [31:0] v);
    in_valid    = 1'b1;
    tree_result = v;
    step();
    in_valid    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (chunk_idx !== 8'd0) $display("FAIL reset_chunk_idx got %0d want 0", chunk_idx); else pass_cnt++;
    total_cnt++; if (result !== 32'd0) $display("FAIL reset_result got %h want 0", result); else pass_cnt++;
    total_cnt++; if (result_valid !== 1'b0) $display("FAIL reset_result_valid got %b want 0", result_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid_acc();
    start_op(8'd4);
    total_cnt++; if (busy !== 1'b1 || in_ready !== 1'b1) $display("FAIL midrst_acc_entry got busy=%b in_ready=%b want 1 1", busy, in_ready); else pass_cnt++;
    send(32'd100);
    send(32'd200);
    total_cnt++; if (chunk_idx !== 8'd2) $display("FAIL midrst_idx got %0d want 2", chunk_idx); else pass_cnt++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL midrst_in_ready got %b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (chunk_idx !== 8'd0) $display("FAIL midrst_idx_clr got %0d want 0", chunk_idx); else pass_cnt++;
    total_cnt++; if (result_valid !== 1'b0) $display("FAIL midrst_rv got %b want 0", result_valid); else pass_cnt++;
    // tree_result must be ignored while idle
    send(32'd77);
    send(32'd88);
    total_cnt++; if (busy !== 1'b0 || result_valid !== 1'b0 || chunk_idx !== 8'd0) $display("FAIL midrst_idle_hold got busy=%b rv=%b idx=%0d want 0 0 0", busy, result_valid, chunk_idx); else pass_cnt++;
  endtask

  task automatic test_basic();
    start_op(8'd3);
    total_cnt++; if (chunk_idx !== 8'd0) $display("FAIL basic_idx0 got %0d want 0", chunk_idx); else pass_cnt++;
    send(32'd10);
    total_cnt++; if (chunk_idx !== 8'd1 || result_valid !== 1'b0) $display("FAIL basic_idx1 got idx=%0d rv=%b want 1 0", chunk_idx, result_valid); else pass_cnt++;
    send(32'd20);
    total_cnt++; if (chunk_idx !== 8'd2 || result_valid !== 1'b0) $display("FAIL basic_idx2 got idx=%0d rv=%b want 2 0", chunk_idx, result_valid); else pass_cnt++;
    send(32'd30);
    total_cnt++; if (result_valid !== 1'b1) $display("FAIL basic_rv got %b want 1", result_valid); else pass_cnt++;
    total_cnt++; if (result !== 32'd60) $display("FAIL basic_result got %0d want 60", result); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL basic_done_flags got in_ready=%b busy=%b want 0 1", in_ready, busy); else pass_cnt++;
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    total_cnt++; if (result_valid !== 1'b0 || busy !== 1'b0 || chunk_idx !== 8'd0) $display("FAIL basic_to_idle got rv=%b busy=%b idx=%0d want 0 0 0", result_valid, busy, chunk_idx); else pass_cnt++;
    total_cnt++; if (result !== 32'd60) $display("FAIL basic_result_hold got %0d want 60", result); else pass_cnt++;
  endtask

  task automatic test_wrap();
    start_op(8'd2);
    send(32'h7FFF_FFFF);
    send(32'h0000_0001);
    total_cnt++; if (result_valid !== 1'b1 || result !== 32'h8000_0000) $display("FAIL wrap_pos got rv=%b res=%h want 1 80000000", result_valid, result); else pass_cnt++;
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    start_op(8'd2);
    send(32'hFFFF_FFFB);
    send(32'd3);
    total_cnt++; if (result_valid !== 1'b1 || result !== 32'hFFFF_FFFE) $display("FAIL wrap_neg got rv=%b res=%h want 1 fffffffe", result_valid, result); else pass_cnt++;
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  task automatic test_stall();
    start_op(8'd2);
    send(32'd5);
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++; if (chunk_idx !== 8'd1 || result_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL stall_hold%0d got idx=%0d rv=%b in_ready=%b want 1 0 1", i, chunk_idx, result_valid, in_ready); else pass_cnt++;
    end
    send(32'd7);
    total_cnt++; if (result_valid !== 1'b1 || result !== 32'd12) $display("FAIL stall_result got rv=%b res=%0d want 1 12", result_valid, result); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++; if (result_valid !== 1'b1 || result !== 32'd12) $display("FAIL backpressure%0d got rv=%b res=%0d want 1 12", i, result_valid, result); else pass_cnt++;
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    total_cnt++; if (result_valid !== 1'b0 || busy !== 1'b0) $display("FAIL stall_release got rv=%b busy=%b want 0 0", result_valid, busy); else pass_cnt++;
  endtask

  task automatic test_zero_and_ignored_start();
    start_op(8'd0);
    total_cnt++; if (result_valid !== 1'b1 || result !== 32'd0) $display("FAIL zero_result got rv=%b res=%0d want 1 0", result_valid, result); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL zero_flags got in_ready=%b busy=%b want 0 1", in_ready, busy); else pass_cnt++;
    send(32'd99);
    total_cnt++; if (result !== 32'd0 || result_valid !== 1'b1) $display("FAIL zero_ignore_tree got rv=%b res=%0d want 1 0", result_valid, result); else pass_cnt++;
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    start_op(8'd2);
    start   = 1'b1;
    vec_num = 8'd9;
    send(32'd4);
    total_cnt++; if (chunk_idx !== 8'd1 || busy !== 1'b1) $display("FAIL ign_start_mid got idx=%0d busy=%b want 1 1", chunk_idx, busy); else pass_cnt++;
    send(32'd6);
    total_cnt++; if (result_valid !== 1'b1 || result !== 32'd10) $display("FAIL ign_start_result got rv=%b res=%0d want 1 10", result_valid, result); else pass_cnt++;
    // start coinciding with the DONE->IDLE edge must not launch a new operation
    vec_num      = 8'd3;
    result_ready = 1'b1;
    step();
    start        = 1'b0;
    result_ready = 1'b0;
    total_cnt++; if (busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL ign_start_release got busy=%b in_ready=%b want 0 0", busy, in_ready); else pass_cnt++;
    step();
    total_cnt++; if (busy !== 1'b0) $display("FAIL ign_start_idle got busy=%b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back_max();
    int idx_err;
    idx_err = 0;
    start_op(8'd255);
    for (int i = 0; i < 255; i++) begin
      total_cnt++;
      if (chunk_idx !== i[7:0] || in_ready !== 1'b1) begin
        idx_err++;
        if (idx_err <= 4) $display("FAIL max_idx%0d got idx=%0d in_ready=%b want %0d 1", i, chunk_idx, in_ready, i);
      end else pass_cnt++;
      in_valid    = 1'b1;
      tree_result = 32'd1;
      step();
    end
    in_valid = 1'b0;
    total_cnt++; if (result_valid !== 1'b1 || result !== 32'd255) $display("FAIL max_result got rv=%b res=%0d want 1 255", result_valid, result); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0 || chunk_idx !== 8'd255) $display("FAIL max_done got in_ready=%b idx=%0d want 0 255", in_ready, chunk_idx); else pass_cnt++;
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    total_cnt++; if (busy !== 1'b0 || chunk_idx !== 8'd0 || result !== 32'd255) $display("FAIL max_release got busy=%b idx=%0d res=%0d want 0 0 255", busy, chunk_idx, result); else pass_cnt++;
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    vec_num      = 8'd0;
    in_valid     = 1'b0;
    tree_result  = 32'd0;
    result_ready = 1'b0;
    test_reset();
    test_reset_mid_acc();
    test_basic();
    test_wrap();
    test_stall();
    test_zero_and_ignored_start();
    test_back_to_back_max();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
